room_navigator: RTL and testbench
=================================

Name: room_navigator

Overview:
- Consumes the `doorcode` exit events that the player block produces and owns the current `room` number, which is fed back to the player block and the level ROM.
- On a valid exit it runs a frame-paced fade-out / swap / fade-in sequence.
- It asserts `freeze` so gameplay halts, and drives `fade_level` to the colour mapper for screen blanking.
- It sits between the player block and the level/palette logic.

Parameters:
- START_ROOM, 0, room loaded on reset.
- ROOM_COLS, 4, map grid columns; room = row*ROOM_COLS + col.
- ROOM_ROWS, 2, map grid rows.
- FADE_MAX, 15, fade_level saturation value; 4-bit field.

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, synchronous, active-high.
- frame_clk, input, 1, vertical-sync-rate frame clock, asynchronous level, sampled on Clk.
- doorcode, input, 3, exit event: 0 none, 1 east, 2 west, 3 north, 4 south, 5-7 invalid.
- room, output, 3, current room number.
- freeze, output, 1, high whenever state != IDLE.
- fade_level, output, 4, 0 = normal picture, FADE_MAX = fully black.
- room_changed, output, 1, one-Clk pulse on the cycle `room` updates.

Behaviour:
- Frame edge: register `frame_clk` on Clk. frame_edge = current & ~delayed. All state advances except SWAP happen only on a frame_edge cycle.
- Event detect:
  - prev_code is registered at every frame_edge in every state.
  - event = frame_edge & (doorcode in 1..4) & (prev_code == 0).
  - A doorcode held over many frames therefore fires once.
  - Values 5-7 never fire but are still stored in prev_code.
- Neighbour lookup, from col = room % ROOM_COLS and row = room / ROOM_COLS:
  - code 1: col+1.
  - code 2: col-1.
  - code 3: row-1.
  - code 4: row+1.
  - Off-grid result gives target = room (blocked).
- States: IDLE, FADE_OUT, SWAP, FADE_IN.
- IDLE:
  - On event with target != room: latch target, fade_level <= 0, go to FADE_OUT.
  - On event with target == room: stay in IDLE, no outputs change.
- FADE_OUT, on frame_edge: if fade_level == FADE_MAX go to SWAP, else fade_level <= fade_level + 1.
- SWAP: exactly one Clk cycle. room <= latched target, room_changed = 1, go to FADE_IN. fade_level stays at FADE_MAX.
- FADE_IN, on frame_edge: if fade_level == 0 go to IDLE, else fade_level <= fade_level - 1.
- Events arriving while not in IDLE are dropped; prev_code still updates.
- Latency, event at frame edge N:
  - FADE_OUT is entered on the next Clk.
  - fade_level = 15 after edge N+15.
  - SWAP follows edge N+16; room updates one Clk later.
  - fade_level = 0 after edge N+31.
  - IDLE is entered after edge N+32.
  - freeze is high for that whole window.
- Reset (synchronous, also mid-sequence):
  - room <= START_ROOM, state <= IDLE.
  - fade_level <= 0, freeze = 0, room_changed = 0.
  - prev_code <= 0, frame_clk delay <= 0.
  - The latched target is discarded.
- Outputs are registered, except freeze and room_changed, which decode state only.

Decomposition:
- Package room_pkg holds:
  - door_t enum: NONE=0, EAST=1, WEST=2, NORTH=3, SOUTH=4.
  - nav_state_t enum.
  - Constants NUM_ROOMS=8, ROOM_COLS, ROOM_ROWS, FADE_MAX.
- Sub-module room_neighbor: purely combinational (room, doorcode) -> (target, blocked).
  - It is shared with a future minimap block.

Test Plan:
- Reset, then doorcode=1 at a frame edge in room 0 -> FADE_OUT; fade_level ramps 0..15 over 15 frames. Check:
  - room changes to 1 one Clk after SWAP.
  - room_changed pulses exactly one cycle.
  - fade_level returns to 0, then IDLE; freeze is high throughout.
- Room 3, doorcode=1 (east off-grid) -> no state change, freeze stays 0, room stays 3. Same for room 0 with doorcode=3.
- Room 1, doorcode=4 held for 40 frames -> exactly one transition to room 5; no retrigger after IDLE is regained while the code is still held.
- During FADE_IN from a 1->2 transition, pulse doorcode=2 -> ignored; room stays 2, sequence timing unchanged.
- Reset asserted at fade_level=9 in FADE_OUT -> next Clk: room=START_ROOM, fade_level=0, freeze=0, state IDLE; a later event works normally.
- doorcode=6 for one frame, then 0 -> no event, no state change.

Source files
------------

// File: rtl/room_pkg.sv
// Shared types and map constants for the room navigation logic.
package room_pkg;

    localparam int unsigned NUM_ROOMS = 8;
    localparam int unsigned ROOM_COLS = 4;
    localparam int unsigned ROOM_ROWS = 2;
    localparam int unsigned FADE_MAX  = 15;

    localparam int unsigned ROOM_W = 3;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned FADE_W = 4;

    typedef enum logic [CODE_W-1:0] {
        NONE  = 3'd0,
        EAST  = 3'd1,
        WEST  = 3'd2,
        NORTH = 3'd3,
        SOUTH = 3'd4
    } door_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        SWAP,
        FADE_IN
    } nav_state_t;

    // True for the four directional exit codes.
    function automatic logic is_move(input logic [CODE_W-1:0] code);
        return (code >= EAST) && (code <= SOUTH);
    endfunction

endpackage

// File: rtl/room_navigator_if.sv
// Player-side exit events in, room / blanking control out.
interface room_navigator_if;
    import room_pkg::*;

    logic              frame_clk;
    logic [CODE_W-1:0] doorcode;
    logic [ROOM_W-1:0] room;
    logic              freeze;
    logic [FADE_W-1:0] fade_level;
    logic              room_changed;

    modport master (
        output frame_clk, doorcode,
        input  room, freeze, fade_level, room_changed
    );

    modport slave (
        input  frame_clk, doorcode,
        output room, freeze, fade_level, room_changed
    );
endinterface

// File: rtl/room_neighbor.sv
// Combinational grid neighbour lookup; off-grid moves return the same room.
module room_neighbor
    import room_pkg::*;
#(
    parameter int unsigned COLS = ROOM_COLS,
    parameter int unsigned ROWS = ROOM_ROWS
) (
    input  logic [ROOM_W-1:0] room,
    input  logic [CODE_W-1:0] doorcode,
    output logic [ROOM_W-1:0] target,
    output logic              blocked
);

    logic [31:0] col;
    logic [31:0] row;
    logic [31:0] ncol;
    logic [31:0] nrow;
    logic        off;

    always_comb begin
        col  = 32'(room) % COLS;
        row  = 32'(room) / COLS;
        ncol = col;
        nrow = row;
        off  = 1'b0;
        case (doorcode)
            EAST:    if (col + 32'd1 >= COLS) off = 1'b1; else ncol = col + 32'd1;
            WEST:    if (col == 32'd0)        off = 1'b1; else ncol = col - 32'd1;
            NORTH:   if (row == 32'd0)        off = 1'b1; else nrow = row - 32'd1;
            SOUTH:   if (row + 32'd1 >= ROWS) off = 1'b1; else nrow = row + 32'd1;
            default: off = 1'b1;
        endcase
        if (!off && (nrow * COLS + ncol) >= NUM_ROOMS)
            off = 1'b1;
        blocked = off;
        target  = off ? room : ROOM_W'(nrow * COLS + ncol);
    end

endmodule

// File: rtl/room_navigator.sv
// Owns the current room; runs a frame-paced fade-out / swap / fade-in on exits.
module room_navigator #(
    parameter int unsigned START_ROOM = 0,
    parameter int unsigned ROOM_COLS  = room_pkg::ROOM_COLS,
    parameter int unsigned ROOM_ROWS  = room_pkg::ROOM_ROWS,
    parameter int unsigned FADE_MAX   = room_pkg::FADE_MAX
) (
    input  logic             Clk,
    input  logic             Reset,
    room_navigator_if.slave  bus
);
    import room_pkg::*;

    localparam logic [FADE_W-1:0] FADE_TOP = FADE_W'(FADE_MAX);
    localparam logic [ROOM_W-1:0] ROOM_RST = ROOM_W'(START_ROOM);

    nav_state_t        state_q, state_d;
    logic [FADE_W-1:0] fade_q, fade_d;
    logic [ROOM_W-1:0] room_q, room_d;
    logic [ROOM_W-1:0] target_q, target_d;
    logic [CODE_W-1:0] prev_q, prev_d;
    logic              frame_d_q;
    logic [ROOM_W-1:0] nb_target;
    logic              nb_blocked;
    logic              frame_edge;
    logic              door_event;

    room_neighbor #(
        .COLS (ROOM_COLS),
        .ROWS (ROOM_ROWS)
    ) u_neighbor (
        .room     (room_q),
        .doorcode (bus.doorcode),
        .target   (nb_target),
        .blocked  (nb_blocked)
    );

    assign frame_edge = bus.frame_clk & ~frame_d_q;
    // Fires only on the first frame a code appears, so a held code cannot retrigger.
    assign door_event = frame_edge & is_move(bus.doorcode) & (prev_q == NONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            fade_q    <= '0;
            room_q    <= ROOM_RST;
            target_q  <= '0;
            prev_q    <= '0;
            frame_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fade_q    <= fade_d;
            room_q    <= room_d;
            target_q  <= target_d;
            prev_q    <= prev_d;
            frame_d_q <= bus.frame_clk;
        end
    end

    always_comb begin
        state_d  = state_q;
        fade_d   = fade_q;
        room_d   = room_q;
        target_d = target_q;
        prev_d   = frame_edge ? bus.doorcode : prev_q;
        case (state_q)
            IDLE: begin
                if (door_event && !nb_blocked && (nb_target != room_q)) begin
                    target_d = nb_target;
                    fade_d   = '0;
                    state_d  = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (frame_edge) begin
                    if (fade_q == FADE_TOP) state_d = SWAP;
                    else                    fade_d  = fade_q + FADE_W'(1);
                end
            end
            SWAP: begin
                room_d  = target_q;
                state_d = FADE_IN;
            end
            FADE_IN: begin
                if (frame_edge) begin
                    if (fade_q == '0) state_d = IDLE;
                    else              fade_d  = fade_q - FADE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.room         = room_q;
    assign bus.fade_level   = fade_q;
    assign bus.freeze       = (state_q != IDLE);
    assign bus.room_changed = (state_q == SWAP);

endmodule

// File: tb/tb_room_navigator.sv
// Scoreboard bench for room_navigator against a frame-level reference model.
module tb_room_navigator;

    localparam int COLS = 4;
    localparam int ROWS = 2;

    typedef struct {
        int room;
        int fade;
        int freeze;
    } frame_exp_t;

    typedef struct {
        int to;
        int frame;
    } swap_exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    room_navigator_if bus ();

    room_navigator #(
        .START_ROOM (0),
        .ROOM_COLS  (4),
        .ROOM_ROWS  (2),
        .FADE_MAX   (15)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_idx = 0;

    frame_exp_t fq[$];
    swap_exp_t  sq[$];

    // Reference model: room, frames elapsed since the accepted exit (-1 when idle).
    int m_room   = 0;
    int m_busy   = -1;
    int m_target = 0;
    int m_prev   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (frame %0d, t=%0t)", name, act, exp, frame_idx, $time);
        end
    endtask

    function automatic int neighbour(input int r, input int code);
        int col = r % COLS;
        int row = r / COLS;
        case (code)
            1: col = col + 1;
            2: col = col - 1;
            3: row = row - 1;
            4: row = row + 1;
            default: return r;
        endcase
        if (col < 0 || col >= COLS || row < 0 || row >= ROWS) return r;
        return row * COLS + col;
    endfunction

    // Whole sequence spans 32 frame edges after the exit: 15 up, swap, 15 down, idle.
    task automatic model_step(input int code);
        frame_exp_t fe;
        int t;
        if (m_busy >= 0) begin
            m_busy++;
            if (m_busy >= 16) m_room = m_target;
            fe.fade   = (m_busy <= 15) ? m_busy : ((m_busy <= 31) ? 31 - m_busy : 0);
            fe.freeze = (m_busy < 32) ? 1 : 0;
            if (m_busy >= 32) m_busy = -1;
        end else begin
            t = neighbour(m_room, code);
            if (code >= 1 && code <= 4 && m_prev == 0 && t != m_room) begin
                m_busy   = 0;
                m_target = t;
                sq.push_back('{to: t, frame: frame_idx + 16});
                fe.fade   = 0;
                fe.freeze = 1;
            end else begin
                fe.fade   = 0;
                fe.freeze = 0;
            end
        end
        fe.room = m_room;
        m_prev  = code;
        fq.push_back(fe);
    endtask

    task automatic frame(input int code);
        @(posedge Clk); #1;
        frame_idx++;
        model_step(code);
        bus.doorcode  = 3'(code);
        bus.frame_clk = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        bus.frame_clk = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) frame(0);
    endtask

    task automatic reset_dut();
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        m_room = 0;
        m_busy = -1;
        m_prev = 0;
        sq.delete();
        @(negedge Clk);
        check("reset_room", int'(bus.room), 0);
        check("reset_fade", int'(bus.fade_level), 0);
        check("reset_freeze", int'(bus.freeze), 0);
        check("reset_room_changed", int'(bus.room_changed), 0);
    endtask

    // Frame monitor: samples outputs two cycles after every frame edge.
    initial begin : frame_mon
        logic last;
        frame_exp_t e;
        last = 1'b0;
        forever begin
            @(negedge Clk);
            if (bus.frame_clk === 1'b1 && !last) begin
                last = 1'b1;
                @(negedge Clk);
                @(negedge Clk);
                if (fq.size() == 0) begin
                    check("frame_queue_nonempty", 0, 1);
                end else begin
                    e = fq.pop_front();
                    check("room", int'(bus.room), e.room);
                    check("fade_level", int'(bus.fade_level), e.fade);
                    check("freeze", int'(bus.freeze), e.freeze);
                end
            end else begin
                last = (bus.frame_clk === 1'b1);
            end
        end
    end

    // Swap monitor: each room_changed pulse must match a pending exit.
    initial begin : swap_mon
        swap_exp_t s;
        forever begin
            @(negedge Clk);
            if (bus.room_changed === 1'b1) begin
                if (sq.size() == 0) begin
                    check("unexpected_room_changed", 1, 0);
                end else begin
                    s = sq.pop_front();
                    check("swap_frame", frame_idx, s.frame);
                    check("swap_fade", int'(bus.fade_level), 15);
                    @(negedge Clk);
                    check("room_changed_width", int'(bus.room_changed), 0);
                    check("room_after_swap", int'(bus.room), s.to);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int code;
        bus.frame_clk = 1'b0;
        bus.doorcode  = 3'd0;
        repeat (3) @(posedge Clk);
        reset_dut();

        idle(3);
        frame(1); idle(35);               // 0 -> 1
        frame(1); idle(20);               // 1 -> 2
        frame(2); idle(15);               // west during fade-in is dropped
        frame(1); idle(35);               // 2 -> 3
        frame(1); idle(5);                // east off-grid from 3

        reset_dut();
        frame(3); idle(5);                // north off-grid from 0
        frame(1); idle(35);               // 0 -> 1
        repeat (40) frame(4);             // held south: single 1 -> 5
        idle(3);
        frame(6); idle(5);                // invalid code

        reset_dut();
        frame(1); idle(9);                // fade_level reaches 9
        reset_dut();
        frame(1); idle(35);               // normal exit after reset

        repeat (300) begin
            code = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            frame(code);
        end
        idle(35);

        repeat (4) @(negedge Clk);
        check("frame_queue_drained", fq.size(), 0);
        check("swap_queue_drained", sq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
